// File: rtl/ltc2387_pkg.sv
// Shared types and constants for the LTC2387 sample stream stage.
package ltc2387_pkg;

  localparam int unsigned ADC_WIDTH_DEF = 18;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Accumulator is wide enough to sum 2^avg_log2 full-scale samples without overflow.
  function automatic int unsigned acc_width(input int unsigned adc_width,
                                            input int unsigned avg_log2);
    return adc_width + avg_log2;
  endfunction

endpackage

// File: rtl/ltc2387_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with extra wrap bit on the pointers.
module ltc2387_sync_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_q;
  logic [PW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_q ^ rd_q) == {1'b1, {PW{1'b0}}};
  assign empty   = (wr_q == rd_q);
  assign level   = wr_q - rd_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head is forced to zero while empty so the output is defined out of reset.
  assign dout    = empty ? '0 : mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[PW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (PW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (PW+1)'(1);
    end
  end

endmodule

// File: rtl/ltc2387_sample_stream.sv
// LTC2387 sample stream: optional block averaging, FWFT buffer, overflow reporting.
// Optional feature macro: LTC2387_DROP_COUNT_EN (saturating dropped-result counter).
module ltc2387_sample_stream
  import ltc2387_pkg::*;
#(
  parameter int unsigned ADC_WIDTH  = ADC_WIDTH_DEF,
  parameter int unsigned AVG_LOG2   = 0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                            sys_clk_int,
  input  logic                            reset_n_int,
  input  logic [ADC_WIDTH-1:0]            adc_data,
  input  logic                            adc_data_valid,
  input  logic                            enable,
  output logic [ADC_WIDTH-1:0]            m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  input  logic                            clear_ovf,
  output logic [15:0]                     drop_cnt
);

  localparam int unsigned ACC_W = acc_width(ADC_WIDTH, AVG_LOG2);
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_sum_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADC_WIDTH-1:0]    res_q;
  logic                    res_valid_q;
  logic                    overflow_q;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    drop;

  always_comb begin
    acc_sum_d = acc_q + ACC_W'(signed'(adc_data));
  end

  always_ff @(posedge sys_clk_int) begin
    if (!reset_n_int) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          acc_q <= '0;
          cnt_q <= '0;
          if (enable) state_q <= ACCUM;
        end
        ACCUM: begin
          if (!enable) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
          end else if (adc_data_valid) begin
            if (cnt_q == CNT_LAST) begin
              res_q       <= ADC_WIDTH'(acc_sum_d >>> AVG_LOG2);
              res_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
            end else begin
              acc_q <= acc_sum_d;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push    = res_valid_q && !fifo_full;
  assign drop    = res_valid_q && fifo_full;
  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;

  ltc2387_sync_fifo #(
    .WIDTH (ADC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk_int),
    .rst_n (reset_n_int),
    .push  (push),
    .din   (res_q),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (m_data),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge sys_clk_int) begin
    if (!reset_n_int) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (clear_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;

`ifdef LTC2387_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;

  // A drop colliding with clear restarts the count at this drop.
  always_ff @(posedge sys_clk_int) begin
    if (!reset_n_int) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      if (clear_ovf)                drop_cnt_q <= 16'd1;
      else if (drop_cnt_q != '1)    drop_cnt_q <= drop_cnt_q + 16'd1;
    end else if (clear_ovf) begin
      drop_cnt_q <= '0;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ltc2387_sample_stream.sv
// Bench: two DUTs (pass-through and 4-sample average) on shared stimulus, queue scoreboard.
module tb_ltc2387_sample_stream;

  localparam int DEPTH = 16;
`ifdef LTC2387_DROP_COUNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] adc_data;
  logic        adc_valid;
  logic        enable;
  logic        m_ready;
  logic        clear_ovf;

  logic [17:0] md [2];
  logic        mv [2];
  logic [4:0]  lv [2];
  logic        ov [2];
  logic [15:0] dc [2];

  always #5 clk = ~clk;

  ltc2387_sample_stream #(.ADC_WIDTH(18), .AVG_LOG2(0), .FIFO_DEPTH(DEPTH)) u_dut0 (
    .sys_clk_int(clk), .reset_n_int(rst_n), .adc_data(adc_data), .adc_data_valid(adc_valid),
    .enable(enable), .m_data(md[0]), .m_valid(mv[0]), .m_ready(m_ready),
    .fifo_level(lv[0]), .overflow(ov[0]), .clear_ovf(clear_ovf), .drop_cnt(dc[0]));

  ltc2387_sample_stream #(.ADC_WIDTH(18), .AVG_LOG2(2), .FIFO_DEPTH(DEPTH)) u_dut2 (
    .sys_clk_int(clk), .reset_n_int(rst_n), .adc_data(adc_data), .adc_data_valid(adc_valid),
    .enable(enable), .m_data(md[1]), .m_valid(mv[1]), .m_ready(m_ready),
    .fifo_level(lv[1]), .overflow(ov[1]), .clear_ovf(clear_ovf), .drop_cnt(dc[1]));

  // ---------------- reference model ----------------
  logic [17:0] q0[$];
  logic [17:0] q1[$];
  int          psum [2];
  int          pn [2];
  bit          st [2];
  bit          pend [2];
  logic [17:0] pval [2];
  int          mcount [2];
  bit          movf [2];
  int          mdrop [2];
  bit          rst_seen;

  function automatic int blk_len(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int floor_div(input int s, input int n);
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  function automatic void push_exp(input int d, input logic [17:0] v);
    if (d == 0) q0.push_back(v);
    else        q1.push_back(v);
  endfunction

  function automatic logic [17:0] pop_exp(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int exp_size(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  always @(posedge clk) begin
    int cnt;
    bit drop;
    int s;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        psum[d] = 0; pn[d] = 0; st[d] = 0; pend[d] = 0;
        mcount[d] = 0; movf[d] = 0; mdrop[d] = 0;
      end
      q0.delete();
      q1.delete();
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
      for (int d = 0; d < 2; d++) begin
        cnt  = mcount[d];
        drop = 1'b0;
        if (pend[d]) begin
          if (cnt == DEPTH) drop = 1'b1;
          else begin
            push_exp(d, pval[d]);
            mcount[d]++;
          end
        end
        if (cnt > 0 && m_ready) mcount[d]--;
        if (drop) begin
          movf[d] = 1'b1;
          if (clear_ovf) mdrop[d] = 1;
          else if (mdrop[d] < 65535) mdrop[d]++;
        end else if (clear_ovf) begin
          movf[d] = 1'b0;
          mdrop[d] = 0;
        end
        pend[d] = 1'b0;
        if (st[d] && enable && adc_valid) begin
          s = int'($signed(adc_data));
          psum[d] += s;
          pn[d]++;
          if (pn[d] == blk_len(d)) begin
            pval[d] = 18'(floor_div(psum[d], pn[d]));
            pend[d] = 1'b1;
            psum[d] = 0;
            pn[d] = 0;
          end
        end else if (!(st[d] && enable)) begin
          psum[d] = 0;
          pn[d] = 0;
        end
        st[d] = enable;
      end
    end
  end

  // ---------------- monitor ----------------
  int n_cmp = 0;
  int n_fail = 0;
  bit end_chk = 1'b0;
  bit mon_done = 1'b0;

  task automatic check(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, d, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check("m_valid", d, 32'(mv[d]), 32'(mcount[d] > 0));
      if (mv[d] === 1'b1 && m_ready) begin
        if (exp_size(d) == 0) check("unexpected_output", d, 32'(md[d]), 32'hFFFF_FFFF);
        else check("m_data", d, 32'(md[d]), 32'(pop_exp(d)));
      end
      check("fifo_level", d, 32'(lv[d]), 32'(mcount[d]));
      check("overflow", d, 32'(ov[d]), 32'(movf[d]));
      check("drop_cnt", d, 32'(dc[d]), DROP_EN ? 32'(mdrop[d]) : 32'd0);
      if (rst_seen) check("reset_m_data", d, 32'(md[d]), 32'd0);
    end
    if (end_chk && !mon_done) begin
      check("leftover0", 0, 32'(q0.size()), 32'd0);
      check("leftover1", 1, 32'(q1.size()), 32'd0);
      mon_done = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [17:0] v);
    adc_data  = v;
    adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
  endtask

  initial begin
    logic [17:0] t2 [4];
    t2 = '{18'h3FFFF, 18'h3FFFE, 18'h00000, 18'h00000};
    rst_n = 1'b0; enable = 1'b0; adc_valid = 1'b0; adc_data = '0;
    m_ready = 1'b1; clear_ovf = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    enable = 1'b1;
    repeat (2) step();

    strobe(18'h1FFFF);
    repeat (4) step();
    enable = 1'b0; step(); enable = 1'b1; step();

    foreach (t2[i]) begin
      strobe(t2[i]);
      repeat (2) step();
    end
    repeat (4) step();

    strobe(18'd100); step(); strobe(18'd100); step();
    enable = 1'b0; step(); enable = 1'b1; step();
    repeat (4) begin strobe(18'd100); step(); end
    repeat (4) step();

    m_ready = 1'b0;
    for (int i = 0; i < 18; i++) strobe(18'($urandom));
    repeat (4) step();
    m_ready = 1'b1;
    repeat (20) step();
    clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
    repeat (2) step();

    m_ready = 1'b0;
    for (int i = 0; i < 18; i++) strobe(18'($urandom));
    repeat (3) step();
    m_ready = 1'b1;
    repeat (11) step();
    m_ready = 1'b0;
    step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    repeat (2) step();

    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(18'($urandom));
    for (int i = 0; i < 200; i++) begin
      m_ready   = ~m_ready;
      adc_data  = 18'($urandom);
      adc_valid = 1'b1;
      step();
    end
    adc_valid = 1'b0;
    m_ready = 1'b1;
    repeat (20) step();
    clear_ovf = 1'b1; step(); clear_ovf = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      adc_valid = 1'($urandom_range(0, 1));
      adc_data  = 18'($urandom);
      m_ready   = ($urandom_range(0, 99) < 60);
      step();
    end

    adc_valid = 1'b0;
    m_ready = 1'b1;
    repeat (40) step();
    end_chk = 1'b1;
    for (int i = 0; i < 10 && !mon_done; i++) step();
    if (!mon_done) begin
      $display("FAIL monitor_done: got 0 expected 1");
      $fatal(1, "monitor did not complete");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
